// File: rtl/morse_key_decoder.sv
// morse_key_decoder
// Receive-side timing decoder for a Morse straight key. The raw key is
// synchronised, debounced, and its key-down / key-up durations are measured
// in Morse units of UNIT_CYCLES clocks. Each mark becomes a dot or a dash,
// symbols are packed into a right-aligned letter code, and letter and word
// gaps are flagged.
//
// Ports:
//   clock         in   system clock (only clock)
//   reset         in   synchronous, active-high reset
//   key           in   raw asynchronous key, 1 = pressed
//   key_db        out  debounced key level
//   symbol_valid  out  one-cycle pulse per completed mark
//   symbol_dash   out  0 = dot, 1 = dash; holds between pulses
//   letter_valid  out  one-cycle pulse at a letter gap (3 units of key-up)
//   letter_code   out  [4:0] symbols, first symbol at bit letter_len-1
//   letter_len    out  [2:0] symbol count 1..5
//   letter_err    out  more than 5 symbols were keyed in the letter
//   word_end      out  one-cycle pulse at a word gap (7 units of key-up)
//   state_dbg     out  [1:0] current FSM state (0 IDLE, 1 MARK, 2 SPACE)
//
// Output contract: there is no back-pressure. symbol_valid, letter_valid and
// word_end are single-cycle, registered strobes; the data that accompanies a
// strobe (symbol_dash, letter_code/len/err) is valid in the strobe cycle and
// holds until the next strobe of the same kind.
module morse_key_decoder #(
  parameter int UNIT_CYCLES     = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key,
  output logic       key_db,
  output logic       symbol_valid,
  output logic       symbol_dash,
  output logic       letter_valid,
  output logic [4:0] letter_code,
  output logic [2:0] letter_len,
  output logic       letter_err,
  output logic       word_end,
  output logic [1:0] state_dbg
);

  localparam int CYC_W = $clog2(UNIT_CYCLES);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------------
  logic            r_sync1;
  logic            r_key_s;
  logic            r_key_db;
  logic [DB_W-1:0] r_db_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_key_s  <= 1'b0;
      r_key_db <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= key;
      r_key_s <= r_sync1;
      if (r_key_s == r_key_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_key_db <= r_key_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Timing FSM and letter assembly
  // ---------------------------------------------------------------------
  state_t           r_state;
  logic [CYC_W-1:0] r_cyc;
  logic [3:0]       r_unit;
  logic [4:0]       r_code;
  logic [2:0]       r_len;
  logic             r_err;
  logic             r_sym_valid;
  logic             r_sym_dash;
  logic             r_let_valid;
  logic [4:0]       r_let_code;
  logic [2:0]       r_let_len;
  logic             r_let_err;
  logic             r_word_end;

  state_t           w_state_nxt;
  logic [CYC_W-1:0] w_cyc_nxt;
  logic [3:0]       w_unit_nxt;
  logic [4:0]       w_code_nxt;
  logic [2:0]       w_len_nxt;
  logic             w_err_nxt;
  logic             w_sym_valid_nxt;
  logic             w_sym_dash_nxt;
  logic             w_let_valid_nxt;
  logic [4:0]       w_let_code_nxt;
  logic [2:0]       w_let_len_nxt;
  logic             w_let_err_nxt;
  logic             w_word_end_nxt;
  logic [CYC_W-1:0] w_cyc_inc;
  logic [3:0]       w_unit_inc;
  logic             w_rollover;
  logic             w_dash;

  always_comb begin
    w_state_nxt     = r_state;
    w_cyc_nxt       = r_cyc;
    w_unit_nxt      = r_unit;
    w_code_nxt      = r_code;
    w_len_nxt       = r_len;
    w_err_nxt       = r_err;
    w_sym_valid_nxt = 1'b0;
    w_sym_dash_nxt  = r_sym_dash;
    w_let_valid_nxt = 1'b0;
    w_let_code_nxt  = r_let_code;
    w_let_len_nxt   = r_let_len;
    w_let_err_nxt   = r_let_err;
    w_word_end_nxt  = 1'b0;

    // Duration counter step; the unit count saturates at 15.
    w_rollover = (r_cyc == CYC_LAST);
    if (w_rollover) begin
      w_cyc_inc  = '0;
      w_unit_inc = (r_unit == 4'd15) ? r_unit : r_unit + 4'd1;
    end else begin
      w_cyc_inc  = r_cyc + 1'b1;
      w_unit_inc = r_unit;
    end
    w_dash = (r_unit >= 4'd2);

    // Counters restart at 1 on entry to MARK/SPACE because the cycle that
    // triggers the transition is already the first cycle of the new level.
    // That makes {r_unit, r_cyc} equal the number of completed cycles of the
    // current level, so thresholds land exactly on multiples of UNIT_CYCLES.
    case (r_state)
      ST_IDLE: begin
        if (r_key_db) begin
          w_state_nxt = ST_MARK;
          w_cyc_nxt   = CYC_ONE;
          w_unit_nxt  = 4'd0;
        end
      end
      ST_MARK: begin
        if (r_key_db) begin
          w_cyc_nxt  = w_cyc_inc;
          w_unit_nxt = w_unit_inc;
        end else begin
          w_sym_valid_nxt = 1'b1;
          w_sym_dash_nxt  = w_dash;
          if (r_len == 3'd5) begin
            w_err_nxt = 1'b1;
          end else begin
            w_code_nxt = {r_code[3:0], w_dash};
            w_len_nxt  = r_len + 3'd1;
          end
          w_state_nxt = ST_SPACE;
          w_cyc_nxt   = CYC_ONE;
          w_unit_nxt  = 4'd0;
        end
      end
      ST_SPACE: begin
        if (r_key_db) begin
          w_state_nxt = ST_MARK;
          w_cyc_nxt   = CYC_ONE;
          w_unit_nxt  = 4'd0;
        end else begin
          w_cyc_nxt  = w_cyc_inc;
          w_unit_nxt = w_unit_inc;
          // This low cycle completes the third unit of the gap.
          if (w_rollover && r_unit == 4'd2) begin
            w_let_valid_nxt = 1'b1;
            w_let_code_nxt  = r_code;
            w_let_len_nxt   = r_len;
            w_let_err_nxt   = r_err;
            w_code_nxt      = 5'd0;
            w_len_nxt       = 3'd0;
            w_err_nxt       = 1'b0;
          end
          // This low cycle completes the seventh unit of the gap.
          if (w_rollover && r_unit == 4'd6) begin
            w_word_end_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
            w_cyc_nxt      = '0;
            w_unit_nxt     = 4'd0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = '0;
        w_unit_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cyc       <= '0;
      r_unit      <= 4'd0;
      r_code      <= 5'd0;
      r_len       <= 3'd0;
      r_err       <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_dash  <= 1'b0;
      r_let_valid <= 1'b0;
      r_let_code  <= 5'd0;
      r_let_len   <= 3'd0;
      r_let_err   <= 1'b0;
      r_word_end  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_unit      <= w_unit_nxt;
      r_code      <= w_code_nxt;
      r_len       <= w_len_nxt;
      r_err       <= w_err_nxt;
      r_sym_valid <= w_sym_valid_nxt;
      r_sym_dash  <= w_sym_dash_nxt;
      r_let_valid <= w_let_valid_nxt;
      r_let_code  <= w_let_code_nxt;
      r_let_len   <= w_let_len_nxt;
      r_let_err   <= w_let_err_nxt;
      r_word_end  <= w_word_end_nxt;
    end
  end

  assign key_db       = r_key_db;
  assign symbol_valid = r_sym_valid;
  assign symbol_dash  = r_sym_dash;
  assign letter_valid = r_let_valid;
  assign letter_code  = r_let_code;
  assign letter_len   = r_let_len;
  assign letter_err   = r_let_err;
  assign word_end     = r_word_end;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Testbench for morse_key_decoder with UNIT_CYCLES=10, DEBOUNCE_CYCLES=4.
// Events seen on the outputs are encoded as {type, err, len, code, dt} where
// dt is the number of cycles from the last key_db fall to the strobe.
module tb_morse_key_decoder;

  localparam int U = 10;
  localparam int D = 4;

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key = 1'b0;
  logic       key_db;
  logic       symbol_valid;
  logic       symbol_dash;
  logic       letter_valid;
  logic [4:0] letter_code;
  logic [2:0] letter_len;
  logic       letter_err;
  logic       word_end;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  morse_key_decoder #(
    .UNIT_CYCLES    (U),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .key         (key),
    .key_db      (key_db),
    .symbol_valid(symbol_valid),
    .symbol_dash (symbol_dash),
    .letter_valid(letter_valid),
    .letter_code (letter_code),
    .letter_len  (letter_len),
    .letter_err  (letter_err),
    .word_end    (word_end),
    .state_dbg   (state_dbg)
  );

  int errors = 0;
  int checks = 0;

  // ------------------------------------------------------------------
  // Scoreboard queues and monitor
  // ------------------------------------------------------------------
  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];
  int          cyc_cnt = 0;
  int          fall_cyc = 0;
  int          db_rises = 0;
  logic        prev_db = 1'b0;

  function automatic logic [18:0] ev(input logic [1:0] t, input logic e,
                                     input logic [2:0] l, input logic [4:0] c,
                                     input int dt);
    logic [7:0] d8;
    d8 = (dt > 255) ? 8'd255 : 8'(dt);
    return {t, e, l, c, d8};
  endfunction

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    prev_db <= key_db;
    if (prev_db && !key_db) fall_cyc <= cyc_cnt;
    if (!prev_db && key_db) db_rises <= db_rises + 1;
    if (symbol_valid) got_q.push_back(ev(2'd0, 1'b0, 3'd0, {4'd0, symbol_dash}, cyc_cnt - fall_cyc));
    if (letter_valid) got_q.push_back(ev(2'd1, letter_err, letter_len, letter_code, cyc_cnt - fall_cyc));
    if (word_end)     got_q.push_back(ev(2'd2, 1'b0, 3'd0, 5'd0, cyc_cnt - fall_cyc));
  end

  // ------------------------------------------------------------------
  // Driver tasks and expectation helpers
  // ------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int p, input int r);
    key = 1'b1;
    tick(p);
    key = 1'b0;
    tick(r);
  endtask

  task automatic exp_sym(input logic dash);
    exp_q.push_back(ev(2'd0, 1'b0, 3'd0, {4'd0, dash}, 1));
  endtask

  task automatic exp_let(input logic [4:0] c, input logic [2:0] l, input logic e);
    exp_q.push_back(ev(2'd1, e, l, c, 3 * U));
  endtask

  task automatic exp_word();
    exp_q.push_back(ev(2'd2, 1'b0, 3'd0, 5'd0, 7 * U));
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_events(input string name);
    logic [18:0] e;
    logic [18:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL %s: missing event, required %h", name, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL %s: event got %h required %h", name, g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d unexpected events, first %h", name, got_q.size(), got_q[0]);
      got_q.delete();
    end
  endtask

  // ------------------------------------------------------------------
  // Stimulus table: single-symbol letters, each followed by a word gap
  // ------------------------------------------------------------------
  typedef struct {
    int   press_cyc;
    int   rel_cyc;
    logic has_sym;
    logic dash;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int rise_wait;
    int rises_before;

    vecs[0] = '{15,  90, 1'b1, 1'b0};
    vecs[1] = '{19,  90, 1'b1, 1'b0};  // 2*U-1 cycles: still a dot
    vecs[2] = '{20,  90, 1'b1, 1'b1};  // 2*U cycles: first dash length
    vecs[3] = '{25,  90, 1'b1, 1'b1};
    vecs[4] = '{5,   90, 1'b1, 1'b0};  // just longer than the debounce
    vecs[5] = '{3,   90, 1'b0, 1'b0};  // glitch: must vanish
    vecs[6] = '{200, 90, 1'b1, 1'b1};  // beyond unit saturation
    vecs[7] = '{30,  90, 1'b1, 1'b1};

    // Reset held with key pressed: everything stays at 0.
    key   = 1'b1;
    reset = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if ({key_db, symbol_valid, symbol_dash, letter_valid, letter_code,
           letter_len, letter_err, word_end, state_dbg} !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs: got %b required all zero",
                 {key_db, symbol_valid, symbol_dash, letter_valid, letter_code,
                  letter_len, letter_err, word_end, state_dbg});
      end
    end
    reset = 1'b0;
    rise_wait = 0;
    while (key_db !== 1'b1 && rise_wait < 20) begin
      tick(1);
      rise_wait++;
    end
    checks++;
    if (rise_wait < 5 || rise_wait > 7) begin
      errors++;
      $display("FAIL reset_release_debounce: key_db rose after %0d cycles required 5..7", rise_wait);
    end
    tick(10);
    key = 1'b0;
    tick(90);
    exp_sym(1'b0);
    exp_let(5'd0, 3'd1, 1'b0);
    exp_word();
    check_events("after_reset_dot");
    check_val("idle_state", state_dbg, 0);

    // Table-driven single-symbol letters.
    for (int i = 0; i < 8; i++) begin
      rises_before = db_rises;
      press(vecs[i].press_cyc, vecs[i].rel_cyc);
      if (vecs[i].has_sym) begin
        exp_sym(vecs[i].dash);
        exp_let({4'd0, vecs[i].dash}, 3'd1, 1'b0);
        exp_word();
      end
      check_events($sformatf("vec%0d_press%0d", i, vecs[i].press_cyc));
      check_val($sformatf("vec%0d_db_rises", i), db_rises - rises_before,
                vecs[i].has_sym ? 1 : 0);
    end

    // Letter "A": dot, short gap, dash.
    press(15, 15);
    press(25, 90);
    exp_sym(1'b0);
    exp_sym(1'b1);
    exp_let(5'b00001, 3'd2, 1'b0);
    exp_word();
    check_events("letter_A");
    check_val("letter_A_code_hold", letter_code, 1);
    check_val("letter_A_len_hold", letter_len, 2);

    // Word gap: dash then a long silence; no repeated strobes.
    press(25, 100);
    exp_sym(1'b1);
    exp_let(5'd1, 3'd1, 1'b0);
    exp_word();
    check_events("word_gap");

    // Press inside units 3..6 of the gap: new letter, no word_end.
    press(25, 50);
    press(10, 90);
    exp_sym(1'b1);
    exp_let(5'd1, 3'd1, 1'b0);
    exp_sym(1'b0);
    exp_let(5'd0, 3'd1, 1'b0);
    exp_word();
    check_events("press_in_word_gap");

    // Gap of 29 cycles: letter continues.
    press(10, 29);
    press(10, 90);
    exp_sym(1'b0);
    exp_sym(1'b0);
    exp_let(5'd0, 3'd2, 1'b0);
    exp_word();
    check_events("gap_29_continues");

    // Gap of exactly 30 cycles: letter fires as the key comes back.
    press(10, 30);
    press(25, 90);
    exp_sym(1'b0);
    exp_let(5'd0, 3'd1, 1'b0);
    exp_sym(1'b1);
    exp_let(5'd1, 3'd1, 1'b0);
    exp_word();
    check_events("gap_30_simultaneous");

    // Overflow: six dots, then a clean letter.
    for (int i = 0; i < 5; i++) press(10, 10);
    press(10, 90);
    for (int i = 0; i < 6; i++) exp_sym(1'b0);
    exp_let(5'd0, 3'd5, 1'b1);
    exp_word();
    check_events("overflow");
    press(25, 90);
    exp_sym(1'b1);
    exp_let(5'd1, 3'd1, 1'b0);
    exp_word();
    check_events("after_overflow");

    // Reset in the middle of a mark after two symbols.
    press(10, 10);
    press(10, 10);
    key = 1'b1;
    tick(22);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    key = 1'b0;
    tick(100);
    exp_sym(1'b0);
    exp_sym(1'b0);
    check_events("reset_mid_mark");
    check_val("reset_mid_mark_state", state_dbg, 0);
    check_val("reset_mid_mark_key_db", key_db, 0);
    press(10, 90);
    exp_sym(1'b0);
    exp_let(5'd0, 3'd1, 1'b0);
    exp_word();
    check_events("after_reset_mid_mark");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Receive-side timing decoder for the Morse trainer. It samples the user's straight-key input, synchronises and debounces it, and measures key-down and key-up durations in Morse units of `UNIT_CYCLES` clocks. Each mark is classified as a dot or a dash, symbols are assembled into a letter code, and letter and word boundaries are flagged. It is the measuring counterpart of the unit-rate clock divider, and its outputs feed the trainer's letter-compare and scoring logic.

## Interface
Parameters:
- `UNIT_CYCLES`, default 25_000_000: clock cycles per Morse unit (0.25 s at 100 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable cycles required before `key_db` changes (10 ms); must be ≥ 1.

Ports:
- `clock`, input, 1: 100 MHz system clock. This is the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `key`, input, 1: raw asynchronous key; 1 = pressed.
- `key_db`, output, 1: debounced key level, used for echo LED and tone.
- `symbol_valid`, output, 1: one-cycle pulse per completed mark.
- `symbol_dash`, output, 1: 0 = dot, 1 = dash. Valid while `symbol_valid` is high; holds otherwise.
- `letter_valid`, output, 1: one-cycle pulse at a letter gap.
- `letter_code`, output, 5: symbols, right-aligned. The first symbol is at bit `letter_len-1`; unused high bits are 0.
- `letter_len`, output, 3: symbol count, 1–5.
- `letter_err`, output, 1: more than 5 symbols were keyed in this letter.
- `word_end`, output, 1: one-cycle pulse at a word gap.

## Operation
- **Input synchronisation:** `key` passes through a 2-flop synchroniser to give `key_s`.
- **Debounce:**
  - The debounce counter clears whenever `key_s == key_db`.
  - `key_db` takes the value of `key_s` once they have differed for `DEBOUNCE_CYCLES` consecutive cycles.
  - Pulses shorter than `DEBOUNCE_CYCLES` never reach the decoder.
- **Duration counting:** a cycle counter (0..`UNIT_CYCLES`-1) and a unit counter (4 bits, saturating at 15). Both clear on every state entry.
- **FSM states:** IDLE, MARK, SPACE.
  - IDLE: waits for `key_db` to go 1, then enters MARK. The shift register is already empty.
  - MARK, on `key_db` falling:
    - Classify the mark as dash if the unit count is ≥ 2, otherwise dot. Every debounced press yields a symbol, and marks longer than 15 units are still dashes.
    - Pulse `symbol_valid` and enter SPACE.
    - Shift register update: `code <= {code[3:0], dash}`; `len <= len+1`.
    - If `len` is already 5, leave `code` and `len` unchanged and set the sticky error flag.
  - SPACE, on `key_db` rising: enter MARK. The letter continues if the gap is under 3 units; if it is 3 units or more, the letter has already been emitted.
  - SPACE, when the unit count reaches 3:
    - Pulse `letter_valid`.
    - Drive `letter_code`, `letter_len` and `letter_err` from the shift register; they hold until the next `letter_valid`.
    - In the same cycle, clear the shift register and the error flag.
  - SPACE, when the unit count reaches 7: pulse `word_end` and enter IDLE.
    - A press during units 3–6 enters MARK without `word_end`.
    - Repeated idle time never re-pulses either flag.
- **Reset:**
  - All outputs go to 0, `key_db` goes to 0, the synchroniser flops clear, the FSM returns to IDLE, and all counters and the shift register clear.
  - Reset mid-mark or mid-letter discards the partial data with no pulses.

## Timing
- **Key-to-debounce latency:** `key_db` changes `2 + DEBOUNCE_CYCLES` cycles (±1) after a stable `key` edge.
- **Symbol:** let cycle N be the first cycle `key_db` = 0. `symbol_valid` and `symbol_dash` are registered high in cycle N+1.
- **Mark length:** counted in cycles of `key_db` = 1.
  - Dash if the length is ≥ 2·`UNIT_CYCLES`.
  - Exactly 2·`UNIT_CYCLES`−1 cycles is a dot.
- **Letter gap:** `letter_valid` is high in the cycle after `key_db` has been 0 for exactly 3·`UNIT_CYCLES` cycles.
- **Word gap:** `word_end` is high in the cycle after 7·`UNIT_CYCLES` low cycles.
- **Simultaneous events:** if `key_db` rises in the same cycle the gap reaches 3 units, `letter_valid` still fires, and the new mark starts a fresh letter.
- **Pulse widths:** all pulse outputs are exactly one cycle wide and registered, with no combinational paths from input to output.

## Test plan
All scenarios use `UNIT_CYCLES`=10 and `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `reset` for 3 cycles with `key`=1 → all outputs 0 throughout. After release, `key_db` rises about 6 cycles later.
- **"A" (dot then dash):**
  - Stimulus: press for 15 cycles, release for 15 cycles, press for 25 cycles, release.
  - Response: `symbol_valid` with dash=0, then dash=1.
  - 30 cycles after the second release: `letter_valid`, `letter_code`=5'b00001, `letter_len`=2, `letter_err`=0.
- **Glitch rejection and boundary:**
  - A 3-cycle key pulse → `key_db` never changes and there is no pulse.
  - A mark of exactly 19 cycles → dot.
  - A mark of exactly 20 cycles → dash.
- **Word gap:**
  - Stimulus: after a dash, hold `key` low for 100 cycles.
  - Response: `letter_valid` at gap cycle 30 (`letter_code`=1, `letter_len`=1) and `word_end` at gap cycle 70, with no further pulses.
  - Then press during gap cycles 30–69 of a second letter → no `word_end`.
- **Overflow:** six dots with 10-cycle gaps → `letter_len`=5, `letter_code`=0, `letter_err`=1. The next letter reports `letter_err`=0.
- **Reset mid-mark:**
  - Stimulus: assert `reset` for 1 cycle during a 25-cycle press, after two prior symbols.
  - Response: no `symbol_valid` or `letter_valid` from the discarded letter. The next dot produces `letter_len`=1.
